// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding,
// default reset PC and a word-alignment helper.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu_fetch_seq.sv
// Instruction fetch sequencer: issues one bus cycle at a time, writes returned
// words to the instruction FIFO and redirects/flushes on branches.
module cpu_fetch_seq
  import cpu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         fetch_en_i,
  input  logic         branch_i,
  input  logic [31:0]  branch_target_i,
  output logic         imem_cyc_o,
  output logic         imem_stb_o,
  output logic [31:0]  imem_adr_o,
  input  logic         imem_ack_i,
  input  logic [31:0]  imem_dat_i,
  output logic         fifo_wr_en_o,
  output logic [31:0]  fifo_data_o,
  input  logic         fifo_full_i,
  output logic         fifo_flush_o,
  output logic [31:0]  fetch_pc_o,
  output fetch_state_e state_o
);

  // Bus handshake: a cycle is open while cyc/stb are high and closes on the
  // cycle imem_ack_i is sampled high; address and strobes never change while open.
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  adr_q, adr_d;
  logic [31:0]  data_q, data_d;
  logic         wr_q, wr_d;
  logic         flush_q, flush_d;
  logic         bus_active;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      adr_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      adr_q   <= adr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    adr_d   = adr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    flush_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (branch_i) begin
          pc_d    = word_align(branch_target_i);
          flush_d = 1'b1;
        // FIFO occupancy lags a write/flush by one cycle, so wait it out.
        end else if (fetch_en_i && !fifo_full_i && !wr_q && !flush_q) begin
          state_d = ST_FETCH;
          adr_d   = word_align(pc_q);
        end
      end
      ST_FETCH: begin
        if (imem_ack_i) begin
          state_d = ST_IDLE;
          if (branch_i) begin
            pc_d    = word_align(branch_target_i);
            flush_d = 1'b1;
          end else begin
            data_d = imem_dat_i;
            wr_d   = 1'b1;
            pc_d   = adr_q + 32'd4;
          end
        end else if (branch_i) begin
          state_d = ST_DRAIN;
          pc_d    = word_align(branch_target_i);
          flush_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        // Stale word still in flight: finish the bus cycle, drop the data.
        if (branch_i) begin
          pc_d    = word_align(branch_target_i);
          flush_d = 1'b1;
        end
        if (imem_ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus_active   = (state_q != ST_IDLE);
  assign imem_cyc_o   = bus_active;
  assign imem_stb_o   = bus_active;
  assign imem_adr_o   = bus_active ? adr_q : '0;
  assign fifo_wr_en_o = wr_q;
  assign fifo_data_o  = data_q;
  assign fifo_flush_o = flush_q;
  assign fetch_pc_o   = pc_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_cpu_fetch_seq.sv
// Directed, table-driven bench for cpu_fetch_seq plus hand-written reset sequence.
module tb_cpu_fetch_seq;
  import cpu_fetch_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         fetch_en_i = 1'b0;
  logic         branch_i = 1'b0;
  logic [31:0]  branch_target_i = '0;
  logic         imem_cyc_o;
  logic         imem_stb_o;
  logic [31:0]  imem_adr_o;
  logic         imem_ack_i = 1'b0;
  logic [31:0]  imem_dat_i = '0;
  logic         fifo_wr_en_o;
  logic [31:0]  fifo_data_o;
  logic         fifo_full_i = 1'b0;
  logic         fifo_flush_o;
  logic [31:0]  fetch_pc_o;
  fetch_state_e state_o;

  int n_vec = 0;
  int n_bad = 0;

  // clock/reset
  always #5 clk_i = ~clk_i;

  cpu_fetch_seq dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .fetch_en_i      (fetch_en_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .imem_cyc_o      (imem_cyc_o),
    .imem_stb_o      (imem_stb_o),
    .imem_adr_o      (imem_adr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_dat_i      (imem_dat_i),
    .fifo_wr_en_o    (fifo_wr_en_o),
    .fifo_data_o     (fifo_data_o),
    .fifo_full_i     (fifo_full_i),
    .fifo_flush_o    (fifo_flush_o),
    .fetch_pc_o      (fetch_pc_o),
    .state_o         (state_o)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] dat;
    logic        full;
    logic        e_cyc;
    logic [31:0] e_adr;
    logic        e_wr;
    logic [31:0] e_data;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rst, input logic en, input logic br, input logic [31:0] tgt,
    input logic ack, input logic [31:0] dat, input logic full,
    input logic e_cyc, input logic [31:0] e_adr, input logic e_wr,
    input logic [31:0] e_data, input logic e_flush, input logic [31:0] e_pc);
    vec_t v;
    v.rst = rst; v.en = en; v.br = br; v.tgt = tgt; v.ack = ack; v.dat = dat;
    v.full = full; v.e_cyc = e_cyc; v.e_adr = e_adr; v.e_wr = e_wr;
    v.e_data = e_data; v.e_flush = e_flush; v.e_pc = e_pc;
    return v;
  endfunction

  // scoreboard compare of every output against the expected record
  task automatic chk(input string nm, input logic e_cyc, input logic [31:0] e_adr,
                     input logic e_wr, input logic [31:0] e_data,
                     input logic e_flush, input logic [31:0] e_pc);
    n_vec++;
    if (imem_cyc_o !== e_cyc || imem_stb_o !== e_cyc || imem_adr_o !== e_adr ||
        fifo_wr_en_o !== e_wr || fifo_data_o !== e_data ||
        fifo_flush_o !== e_flush || fetch_pc_o !== e_pc) begin
      n_bad++;
      $display("FAIL %s: got cyc=%b stb=%b adr=%h wr=%b data=%h flush=%b pc=%h, want cyc=%b adr=%h wr=%b data=%h flush=%b pc=%h",
               nm, imem_cyc_o, imem_stb_o, imem_adr_o, fifo_wr_en_o, fifo_data_o,
               fifo_flush_o, fetch_pc_o, e_cyc, e_adr, e_wr, e_data, e_flush, e_pc);
    end
  endtask

  initial begin
    // after reset, A = first fetched word, B = second, C = wrap fetch
    logic [31:0] wa, wb, wc;
    bit seen;
    wa = 32'hA5A5_0001;
    wb = 32'h1111_2222;
    wc = 32'hCAFE_F00D;

    //            rst en br tgt           ack dat           full  cyc adr           wr data   flush pc
    vecs.push_back(mk(1, 1, 0, 0,            0, 0,            0,   0, 0,            0, 0,  0, 32'h1000)); // reset state
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0,   0, 0,            0, 0,  0, 32'h1000));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0,   1, 32'h1000,     0, 0,  0, 32'h1000)); // wait cycle
    vecs.push_back(mk(0, 1, 0, 0,            1, wa,           0,   1, 32'h1000,     0, 0,  0, 32'h1000)); // ack
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0,   0, 0,            1, wa, 0, 32'h1004)); // write
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0,   0, 0,            0, wa, 0, 32'h1004));
    vecs.push_back(mk(0, 1, 0, 0,            1, wb,           1,   1, 32'h1004,     0, wa, 0, 32'h1004)); // full never aborts
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            1,   0, 0,            1, wb, 0, 32'h1008));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 1, 0, 0,          0, 0,            1,   0, 0,            0, wb, 0, 32'h1008)); // held full
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0,   0, 0,            0, wb, 0, 32'h1008)); // full drops
    vecs.push_back(mk(0, 1, 1, 32'h2002,     0, 0,            0,   1, 32'h1008,     0, wb, 0, 32'h1008)); // branch in FETCH
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0,   1, 32'h1008,     0, wb, 1, 32'h2000));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0,   1, 32'h1008,     0, wb, 0, 32'h2000));
    vecs.push_back(mk(0, 1, 0, 0,            1, 32'hDEADBEEF, 0,   1, 32'h1008,     0, wb, 0, 32'h2000)); // drain ack
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0,   0, 0,            0, wb, 0, 32'h2000));
    vecs.push_back(mk(0, 1, 1, 32'h3000,     1, 32'hBAD0BAD0, 0,   1, 32'h2000,     0, wb, 0, 32'h2000)); // branch+ack
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0,   0, 0,            0, wb, 1, 32'h3000));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0,   0, 0,            0, wb, 0, 32'h3000));
    vecs.push_back(mk(0, 1, 1, 32'h4000,     0, 0,            0,   1, 32'h3000,     0, wb, 0, 32'h3000)); // to DRAIN
    vecs.push_back(mk(0, 1, 1, 32'h5004,     0, 0,            0,   1, 32'h3000,     0, wb, 1, 32'h4000)); // second target
    vecs.push_back(mk(0, 0, 0, 0,            1, 32'h0BADF00D, 0,   1, 32'h3000,     0, wb, 1, 32'h5004));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0,   0, 0,            0, wb, 0, 32'h5004));
    vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFF, 0, 0,            0,   0, 0,            0, wb, 0, 32'h5004)); // branch in IDLE
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0,   0, 0,            0, wb, 1, 32'hFFFFFFFC));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0,   0, 0,            0, wb, 0, 32'hFFFFFFFC));
    vecs.push_back(mk(0, 0, 0, 0,            1, wc,           0,   1, 32'hFFFFFFFC, 0, wb, 0, 32'hFFFFFFFC)); // en low, completes
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0,   0, 0,            1, wc, 0, 32'h0000_0000)); // wrap
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0,   0, 0,            0, wc, 0, 32'h0000_0000));

    // reset held over a couple of edges before the table
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);

    // driver loop: inputs on the falling edge, outputs checked just after
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_i);
      rst_i           = vecs[i].rst;
      fetch_en_i      = vecs[i].en;
      branch_i        = vecs[i].br;
      branch_target_i = vecs[i].tgt;
      imem_ack_i      = vecs[i].ack;
      imem_dat_i      = vecs[i].dat;
      fifo_full_i     = vecs[i].full;
      #1;
      chk($sformatf("vec%0d", i), vecs[i].e_cyc, vecs[i].e_adr, vecs[i].e_wr,
          vecs[i].e_data, vecs[i].e_flush, vecs[i].e_pc);
    end

    // reset while a bus cycle is open
    @(negedge clk_i);
    fetch_en_i = 1'b1;
    branch_i   = 1'b0;
    imem_ack_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk_i);
      #1;
      seen = imem_cyc_o;
    end
    n_vec++;
    if (!seen) begin
      n_bad++;
      $display("FAIL cyc_timeout: got cyc=0 within 5 cycles, want cyc=1");
    end
    chk("open_cycle", 1'b1, 32'h0000_0000, 1'b0, wc, 1'b0, 32'h0000_0000);
    rst_i      = 1'b1;
    imem_ack_i = 1'b1;
    imem_dat_i = 32'h7777_7777;
    #1;
    chk("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h1000);
    @(negedge clk_i);
    rst_i      = 1'b0;
    imem_ack_i = 1'b0;
    #1;
    chk("rst_release", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h1000);
    @(negedge clk_i);
    #1;
    chk("refetch", 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0, 32'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // wr and flush must never coincide
  always @(negedge clk_i) begin
    if (!rst_i && fifo_wr_en_o && fifo_flush_o) begin
      n_vec++;
      n_bad++;
      $display("FAIL wr_flush_overlap: got wr=1 flush=1, want at most one high");
    end
  end

endmodule
